// File: rtl/dmem_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_arbiter
// Two-master arbiter in front of a single-port data memory.
//
// Ownership is tracked by a small registered FSM (IDLE / OWN0 / OWN1). Each
// cycle the current owner keeps its request high, it completes one access.
// Everything going to memory is a combinational mux of the owner state and the
// owning master's inputs, so an owned cycle costs no extra latency.
//
// Fairness:
//   - A tie from IDLE goes to the master that did not own last.
//   - While both masters request, the owner is granted at most HOLD_MAX
//     consecutive cycles before ownership moves to the waiting master.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   m<i>_req                   master request, held until m<i>_ready
//   m<i>_wr_en                 1 = store, 0 = load
//   m<i>_addr, m<i>_wdata      byte address and store data
//   m<i>_storeType/_loadType   width codes, passed straight through
//   m<i>_ready                 access performed this cycle
//   m<i>_rdata                 load data, zero unless m<i>_ready
//   mem_*                      data memory interface (mem_rdata is comb.)
// ----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int HOLD_MAX = 8
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_req,
    input  logic        m0_wr_en,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [1:0]  m0_storeType,
    input  logic [2:0]  m0_loadType,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,

    input  logic        m1_req,
    input  logic        m1_wr_en,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [1:0]  m1_storeType,
    input  logic [2:0]  m1_loadType,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,

    output logic        mem_wr_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_storeType,
    output logic [2:0]  mem_loadType,
    input  logic [31:0] mem_rdata
);

    localparam int CNT_W = $clog2(HOLD_MAX) + 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } ownerState_t;

    ownerState_t      ownerState;
    logic             lastOwner;
    logic [CNT_W-1:0] holdCount;

    logic grant0;
    logic grant1;

    // Reset also gates the grants directly so a store in flight is dropped
    // the instant reset rises, not only once the state flops have cleared.
    assign grant0 = !reset && (ownerState == OWN0) && m0_req;
    assign grant1 = !reset && (ownerState == OWN1) && m1_req;

    always_comb begin
        mem_wr_en     = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        mem_storeType = '0;
        mem_loadType  = '0;
        if (grant0) begin
            mem_wr_en     = m0_wr_en;
            mem_addr      = m0_addr;
            mem_wdata     = m0_wdata;
            mem_storeType = m0_storeType;
            mem_loadType  = m0_loadType;
        end else if (grant1) begin
            mem_wr_en     = m1_wr_en;
            mem_addr      = m1_addr;
            mem_wdata     = m1_wdata;
            mem_storeType = m1_storeType;
            mem_loadType  = m1_loadType;
        end
    end

    assign m0_ready = grant0;
    assign m1_ready = grant1;
    assign m0_rdata = grant0 ? mem_rdata : '0;
    assign m1_rdata = grant1 ? mem_rdata : '0;

    // lastOwner resets to 1 so master 0 wins the first tie after reset.
    // holdCount only advances while the other master is actually waiting and
    // clears on every ownership change, so it never passes HOLD_LAST.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ownerState <= IDLE;
            lastOwner  <= 1'b1;
            holdCount  <= '0;
        end else begin
            case (ownerState)
                IDLE: begin
                    holdCount <= '0;
                    if (m0_req && m1_req) begin
                        if (lastOwner) begin
                            ownerState <= OWN0;
                            lastOwner  <= 1'b0;
                        end else begin
                            ownerState <= OWN1;
                            lastOwner  <= 1'b1;
                        end
                    end else if (m0_req) begin
                        ownerState <= OWN0;
                        lastOwner  <= 1'b0;
                    end else if (m1_req) begin
                        ownerState <= OWN1;
                        lastOwner  <= 1'b1;
                    end
                end
                OWN0: begin
                    if (!m0_req) begin
                        holdCount <= '0;
                        if (m1_req) begin
                            ownerState <= OWN1;
                            lastOwner  <= 1'b1;
                        end else begin
                            ownerState <= IDLE;
                        end
                    end else if (m1_req) begin
                        if (holdCount == HOLD_LAST) begin
                            ownerState <= OWN1;
                            lastOwner  <= 1'b1;
                            holdCount  <= '0;
                        end else begin
                            holdCount <= holdCount + 1'b1;
                        end
                    end
                end
                OWN1: begin
                    if (!m1_req) begin
                        holdCount <= '0;
                        if (m0_req) begin
                            ownerState <= OWN0;
                            lastOwner  <= 1'b0;
                        end else begin
                            ownerState <= IDLE;
                        end
                    end else if (m0_req) begin
                        if (holdCount == HOLD_LAST) begin
                            ownerState <= OWN0;
                            lastOwner  <= 1'b0;
                            holdCount  <= '0;
                        end else begin
                            holdCount <= holdCount + 1'b1;
                        end
                    end
                end
                default: begin
                    ownerState <= IDLE;
                    holdCount  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed bench for dmem_arbiter. Stimulus pushes the expected memory-side
// view of each access into a queue; a monitor on the falling edge pops one
// entry whenever either master sees ready and compares routing, width codes
// and load data. Timing-specific behaviour (latency, tie order, hold limit,
// owner drop, reset in the middle of a store) is checked inline.
// A small word-addressed memory model supplies mem_rdata and absorbs stores.
// Initial memory word k holds 32'hA500_0000 + k.
// ----------------------------------------------------------------------------
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        m0_req, m0_wr_en, m1_req, m1_wr_en;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [1:0]  m0_storeType, m1_storeType;
    logic [2:0]  m0_loadType, m1_loadType;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_wr_en;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  mem_storeType;
    logic [2:0]  mem_loadType;

    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.HOLD_MAX(8)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_wr_en(m0_wr_en), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_storeType(m0_storeType), .m0_loadType(m0_loadType),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_wr_en(m1_wr_en), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_storeType(m1_storeType), .m1_loadType(m1_loadType),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_storeType(mem_storeType), .mem_loadType(mem_loadType),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory model
    logic [31:0] mem [0:63];
    initial begin
        for (int k = 0; k < 64; k++) mem[k] <= 32'hA500_0000 + k;
    end
    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr[7:2]] <= mem_wdata;
    end

    // Scoreboard
    typedef struct {
        bit          m;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  st;
        logic [2:0]  lt;
        logic [31:0] rdata;
    } sbItem_t;

    sbItem_t sbq[$];
    sbItem_t monItem;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic push(input bit m, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] st, input logic [2:0] lt, input logic [31:0] rd);
        sbItem_t it;
        it.m = m; it.wr = wr; it.addr = a; it.wdata = wd; it.st = st; it.lt = lt; it.rdata = rd;
        sbq.push_back(it);
    endtask

    always @(negedge clk) begin
        if (m0_ready || m1_ready) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready actual m0=%0b m1=%0b required none", m0_ready, m1_ready);
            end else begin
                monItem = sbq.pop_front();
                $display("txn t=%0t m%0d wr=%0b addr=0x%08h", $time, m1_ready, mem_wr_en, mem_addr);
                chk("sb_master", {31'd0, m1_ready}, {31'd0, monItem.m});
                chk("sb_single_ready", {31'd0, m0_ready & m1_ready}, 32'd0);
                chk("sb_wr_en", {31'd0, mem_wr_en}, {31'd0, monItem.wr});
                chk("sb_addr", mem_addr, monItem.addr);
                chk("sb_storeType", {30'd0, mem_storeType}, {30'd0, monItem.st});
                chk("sb_loadType", {29'd0, mem_loadType}, {29'd0, monItem.lt});
                if (monItem.wr) chk("sb_wdata", mem_wdata, monItem.wdata);
                if (monItem.m) begin
                    if (!monItem.wr) chk("sb_m1_rdata", m1_rdata, monItem.rdata);
                    chk("sb_m0_rdata_zero", m0_rdata, 32'd0);
                end else begin
                    if (!monItem.wr) chk("sb_m0_rdata", m0_rdata, monItem.rdata);
                    chk("sb_m1_rdata_zero", m1_rdata, 32'd0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setM(input bit m, input logic req, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [1:0] st, input logic [2:0] lt);
        if (m) begin
            m1_req = req; m1_wr_en = wr; m1_addr = a; m1_wdata = wd; m1_storeType = st; m1_loadType = lt;
        end else begin
            m0_req = req; m0_wr_en = wr; m0_addr = a; m0_wdata = wd; m0_storeType = st; m0_loadType = lt;
        end
    endtask

    // One access: raise req, wait (bounded) for ready, drop req next cycle.
    // lat counts falling edges up to and including the ready one.
    task automatic access(input bit m, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic [1:0] st, input logic [2:0] lt, input logic [31:0] rd,
                          output int lat);
        bit got;
        got = 1'b0;
        lat = 0;
        push(m, wr, a, wd, st, lt, rd);
        setM(m, 1'b1, wr, a, wd, st, lt);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            lat++;
            if (m ? m1_ready : m0_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL access_timeout actual no ready required ready for m%0d", m);
        end
        tick();
        if (m) m1_req = 1'b0; else m0_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        reset = 1'b1;
        setM(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 3'd0);
        setM(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 3'd0);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_m0_ready", {31'd0, m0_ready}, 32'd0);
        chk("rst_m1_ready", {31'd0, m1_ready}, 32'd0);
        chk("rst_mem_wr_en", {31'd0, mem_wr_en}, 32'd0);
        chk("rst_m0_rdata", m0_rdata, 32'd0);
        chk("rst_m1_rdata", m1_rdata, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);

        // Tie right after reset: m0 first, m1 one cycle after m0 drops
        tick();
        reset = 1'b0;
        push(1'b0, 1'b1, 32'h40, 32'h1111_1111, 2'd2, 3'd0, 32'd0);
        push(1'b1, 1'b0, 32'h44, 32'd0, 2'd0, 3'b010, 32'hA500_0011);
        setM(1'b0, 1'b1, 1'b1, 32'h40, 32'h1111_1111, 2'd2, 3'd0);
        setM(1'b1, 1'b1, 1'b0, 32'h44, 32'd0, 2'd0, 3'b010);
        @(negedge clk);
        chk("tie_idle_ready", {30'd0, m1_ready, m0_ready}, 32'd0);
        tick();
        @(negedge clk);
        chk("tie_first_grant", {30'd0, m1_ready, m0_ready}, 32'd1);
        tick();
        m0_req = 1'b0;
        @(negedge clk);
        chk("tie_switch_gap", {30'd0, m1_ready, m0_ready}, 32'd0);
        tick();
        @(negedge clk);
        chk("tie_second_grant", {30'd0, m1_ready, m0_ready}, 32'd2);
        tick();
        m1_req = 1'b0;
        tick();

        // Single store from IDLE, then readback in the following owned cycle
        access(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 2'd2, 3'd0, 32'd0, lat);
        chk("store_latency", lat, 32'd2);
        access(1'b0, 1'b0, 32'h10, 32'd0, 2'd0, 3'b010, 32'hDEAD_BEEF, lat);
        chk("readback_latency", lat, 32'd1);
        tick();

        // m1 load pass-through with an unaligned address
        access(1'b1, 1'b0, 32'h21, 32'd0, 2'd0, 3'b100, 32'hA500_0008, lat);
        chk("passthru_latency", lat, 32'd2);
        tick();

        // Hold limit: m0 streams, m1 raises; m0 gets 8 more cycles, m1 the 9th
        push(1'b0, 1'b0, 32'h0, 32'd0, 2'd0, 3'b010, 32'hA500_0000);
        setM(1'b0, 1'b1, 1'b0, 32'h0, 32'd0, 2'd0, 3'b010);
        tick();
        @(negedge clk);
        chk("hold_m0_alone", {30'd0, m1_ready, m0_ready}, 32'd1);
        tick();
        for (int k = 0; k < 8; k++) push(1'b0, 1'b0, 32'h0, 32'd0, 2'd0, 3'b010, 32'hA500_0000);
        push(1'b1, 1'b1, 32'h80, 32'hCAFE_F00D, 2'd1, 3'd0, 32'd0);
        setM(1'b1, 1'b1, 1'b1, 32'h80, 32'hCAFE_F00D, 2'd1, 3'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("hold_m0_cycle%0d", k), {30'd0, m1_ready, m0_ready}, 32'd1);
            tick();
        end
        @(negedge clk);
        chk("hold_m1_takes_over", {30'd0, m1_ready, m0_ready}, 32'd2);
        tick();

        // Owner drop: OWN1, m1 drops req with wr_en still high, m0 idle
        m0_req = 1'b0;
        m1_req = 1'b0;
        @(negedge clk);
        chk("drop_wr_gated", {31'd0, mem_wr_en}, 32'd0);
        chk("drop_no_ready", {30'd0, m1_ready, m0_ready}, 32'd0);
        tick();
        // Back in IDLE: a fresh request must take the two-edge IDLE path
        access(1'b1, 1'b1, 32'h84, 32'h1234_5678, 2'd2, 3'd0, 32'd0, lat);
        chk("drop_then_idle_latency", lat, 32'd2);
        tick();

        // Reset in the middle of an owned store cycle
        setM(1'b0, 1'b1, 1'b1, 32'hC0, 32'h0BAD_F00D, 2'd2, 3'd0);
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid_wr_en", {31'd0, mem_wr_en}, 32'd0);
        chk("rst_mid_ready", {31'd0, m0_ready}, 32'd0);
        tick();
        chk("rst_mid_mem_unchanged", mem[6'h30], 32'hA500_0030);
        // Release with both requesting: m0 must win (last owner forced to 1)
        push(1'b0, 1'b1, 32'hC0, 32'h0BAD_F00D, 2'd2, 3'd0, 32'd0);
        push(1'b1, 1'b0, 32'h84, 32'd0, 2'd0, 3'b010, 32'h1234_5678);
        setM(1'b1, 1'b1, 1'b0, 32'h84, 32'd0, 2'd0, 3'b010);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", {30'd0, m1_ready, m0_ready}, 32'd0);
        tick();
        @(negedge clk);
        chk("post_rst_first_m0", {30'd0, m1_ready, m0_ready}, 32'd1);
        tick();
        m0_req = 1'b0;
        @(negedge clk);
        chk("post_rst_gap", {30'd0, m1_ready, m0_ready}, 32'd0);
        tick();
        @(negedge clk);
        chk("post_rst_then_m1", {30'd0, m1_ready, m0_ready}, 32'd2);
        tick();
        m1_req = 1'b0;
        repeat (3) tick();

        chk("sb_drained", sbq.size(), 32'd0);
        chk("final_store_word", mem[6'h30], 32'h0BAD_F00D);
        chk("hold_store_word", mem[6'h20], 32'hCAFE_F00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL expose parameter HOLD_MAX, default 8: maximum consecutive granted cycles for one master while the other master is requesting.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 m0_req / m1_req  input  1  master request; held until m<i>_ready is seen.
REQ-005 m0_wr_en / m1_wr_en  input  1  1 = store, 0 = load.
REQ-006 m0_addr / m1_addr  input  32  byte address.
REQ-007 m0_wdata / m1_wdata  input  32  store data.
REQ-008 m0_storeType / m1_storeType  input  2  store width code, passed through unchanged.
REQ-009 m0_loadType / m1_loadType  input  3  load width/sign code, passed through unchanged.
REQ-010 m0_ready / m1_ready  output  1  access performed this cycle.
REQ-011 m0_rdata / m1_rdata  output  32  load data; valid only when m<i>_ready=1, otherwise 0.
REQ-012 mem_wr_en  output  1  write enable to data memory.
REQ-013 mem_addr, mem_wdata  output  32 each  address and store data to data memory.
REQ-014 mem_storeType / mem_loadType  output  2 / 3  width codes to data memory.
REQ-015 mem_rdata  input  32  combinational read data from data memory.

Function
REQ-016 State SHALL be a registered owner FSM: IDLE, OWN0, OWN1; plus a last-owner bit and a hold counter of width clog2(HOLD_MAX)+1.
REQ-017 In OWN<i>, when m<i>_req=1, the block SHALL route master i's addr/wdata/storeType/loadType to mem_*, drive mem_wr_en=m<i>_wr_en, m<i>_ready=1, m<i>_rdata=mem_rdata.
REQ-018 In IDLE, or in OWN<i> with m<i>_req=0, the block SHALL drive mem_wr_en=0, mem_addr/mem_wdata=0, mem_storeType/mem_loadType=0, and both ready=0.
REQ-019 The non-owner's ready and rdata SHALL always be 0.
REQ-020 Next-owner decision at each edge: IDLE, one req -> that master; IDLE, both req -> master != last-owner.
REQ-021 OWN<i>: m<i>_req=0 -> OWN<other> if other req, else IDLE.
REQ-022 OWN<i>: m<i>_req=1 and other req=0 -> stay OWN<i>.
REQ-023 OWN<i>: both req and hold counter = HOLD_MAX-1 -> OWN<other>; otherwise stay.
REQ-024 The hold counter SHALL increment each cycle the owner is ready while the other master requests, reset to 0 on every owner change, and hold when the other master is not requesting; it SHALL never exceed HOLD_MAX-1.
REQ-025 The last-owner bit SHALL update to i on every entry into OWN<i>.
REQ-026 Latency: request raised in cycle N with arbiter in IDLE SHALL see ready in cycle N+1; each owned cycle with req=1 completes exactly one access; a store is written at the end of its ready cycle.
REQ-027 A master dropping req in its owned cycle SHALL cause no memory access that cycle (wr_en gated).
REQ-028 A master request raised while the other owns SHALL wait without ready; worst-case wait is HOLD_MAX+1 cycles.
REQ-029 Outputs to memory SHALL be purely a mux of registered state and master inputs; no memory signal SHALL be registered.

Reset
REQ-030 Asserting reset SHALL immediately force IDLE, last-owner=1 (so m0 wins first tie), hold counter=0, mem_wr_en=0, all ready=0, all rdata=0, regardless of clock.
REQ-031 A store in flight when reset asserts SHALL be suppressed (mem_wr_en falls asynchronously).
REQ-032 After reset release, first grant SHALL follow REQ-020 with no extra idle cycles.

Verification
REQ-033 Single store: m0 req, wr_en=1, addr=0x10, wdata=0xDEADBEEF, storeType=2 -> cycle+1 m0_ready=1, mem_wr_en=1, mem_addr=0x10; readback load from 0x10 returns 0xDEADBEEF.
REQ-034 Tie: m0 and m1 req same cycle after reset -> m0 granted first; after m0 drops req, m1 granted next cycle.
REQ-035 Starvation bound: m0 held req, m1 req raised, HOLD_MAX=8 -> m0 gets exactly 8 ready cycles after m1 raises, then m1 owns on the 9th cycle.
REQ-036 Owner drop: OWN1, m1_req falls, m0 idle -> mem_wr_en=0 that cycle, IDLE next cycle, no ready to either master.
REQ-037 Reset mid-store: OWN0 with wr_en=1, reset asserted mid-cycle -> mem_wr_en=0 before next edge, memory word unchanged, FSM IDLE.
REQ-038 Pass-through: m1 load with loadType=3'b100, addr=0x21 -> mem_loadType=3'b100, mem_addr=0x21, m1_rdata equals mem_rdata, m0_rdata=0.
